// File: rtl/aes_pipe_sched.sv
// aes_pipe_sched
// Issue controller for a fully pipelined, non-stallable AES-128 core.
// Plaintext blocks are accepted over a valid/ready stream and issued to the
// core one per cycle. Each issued block is tracked by a valid/tag shift
// register that mirrors the core pipeline depth. When a tracked block leaves
// the last stage, the core's ciphertext and the block's tag are written into
// an output FIFO. Input credit counts both in-flight and buffered blocks, so
// the FIFO cannot overflow even under unlimited downstream backpressure.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   key_load, key_in  load a new active key (single-cycle pulse)
//   in_valid/in_ready/in_data/in_tag       plaintext input stream
//   core_state, core_key                   to the AES core inputs
//   core_out                               ciphertext from the core
//   out_valid/out_ready/out_data/out_tag   ciphertext output stream (FIFO head)
//   busy              a block is in flight or buffered
//   done_count        blocks popped since reset (wraps)
//   fsm_state         debug view of the FSM: 0 = NO_KEY, 1 = KEYED
//
// Handshake: on both streams a transfer happens at a rising edge where
// valid and ready are both 1. in_ready may fall while in_valid is high; the
// source holds in_data/in_tag until the transfer. out_data/out_tag are stable
// while out_valid is 1 and no pop happens.
module aes_pipe_sched #(
    parameter int LATENCY    = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [127:0]     key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [127:0]     core_state,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [31:0]      done_count,
    output logic             fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    // Wide enough to hold inflight + fifo_count without wrapping.
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int EW = 128 + TAG_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        NO_KEY = 1'b0,
        KEYED  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [127:0]       key_reg;
    logic [127:0]       issued_q;
    logic [LATENCY-1:0] vld_sr;
    logic [TAG_W-1:0]   tag_sr [LATENCY];
    logic [CW-1:0]      inflight;
    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      fifo_count;
    logic               accept;
    logic               retire;
    logic               pop;
    logic               empty;
    logic               full;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NO_KEY;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready uses registered counts only: a pop in the current cycle does
    // not return credit until the following cycle.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            NO_KEY: begin
                if (key_load) begin
                    state_d = KEYED;
                end
            end
            KEYED: begin
                in_ready = (inflight + CW'(fifo_count)) < DEPTH_C;
            end
            default: begin
                state_d = NO_KEY;
            end
        endcase
    end

    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // Issue and key
    // ------------------------------------------------------------------
    assign accept = in_valid & in_ready;

    // Idle cycles repeat the last issued block rather than exposing new data.
    assign core_state = accept ? in_data : issued_q;
    // Registered key: a block accepted alongside key_load still sees the old
    // key. The core carries the key with each block, so no drain is needed.
    assign core_key   = key_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg  <= '0;
            issued_q <= '0;
        end else begin
            if (key_load) begin
                key_reg <= key_in;
            end
            if (accept) begin
                issued_q <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking
    // ------------------------------------------------------------------
    assign retire = vld_sr[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr   <= '0;
            inflight <= '0;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], accept};
            case ({accept, retire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Tags need no reset: they are only consumed when the matching vld_sr
    // bit is set, and vld_sr is reset.
    always_ff @(posedge clk) begin
        tag_sr[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_sr[i] <= tag_sr[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (circular buffer, extra pointer bit distinguishes full)
    // ------------------------------------------------------------------
    assign fifo_count = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign out_valid  = !empty;
    assign pop        = out_valid & out_ready;

    // Masked when empty so that outputs read as zero after reset.
    assign {out_data, out_tag} = empty ? {EW{1'b0}} : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (retire && !rst) begin
            mem[wr_ptr[AW-1:0]] <= {core_out, tag_sr[LATENCY-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            done_count <= '0;
        end else begin
            if (retire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                done_count <= done_count + 32'd1;
            end
        end
    end

    assign busy = (inflight != '0) || (fifo_count != '0);

    // The credit scheme makes this unreachable; it guards the invariant.
    write_when_full: assert property (@(posedge clk) disable iff (rst) !(retire && full));

endmodule

// File: tb/tb_aes_pipe_sched.sv
// tb_aes_pipe_sched
// Bench for aes_pipe_sched. A behavioural AES-128 core (pipelined delay of
// LATENCY cycles around a functional encrypt) feeds core_out. The driver
// pushes the expected {ciphertext, tag} for every accepted block into exp_q,
// computed from the plaintext and the key that was active before that cycle.
// A monitor pops exp_q on every output transfer and compares. Directed
// phases check the published AES vectors, latency, credit limits,
// throughput and mid-run reset.
module tb_aes_pipe_sched;

    localparam int LATENCY    = 11;
    localparam int FIFO_DEPTH = 16;
    localparam int TAG_W      = 8;
    localparam int EW         = 128 + TAG_W;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic             clk = 1'b0;
    logic             rst;
    logic             key_load;
    logic [127:0]     key_in;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic [127:0]     core_state;
    logic [127:0]     core_key;
    logic [127:0]     core_out;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [31:0]      done_count;
    logic             fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    aes_pipe_sched #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .busy       (busy),
        .done_count (done_count),
        .fsm_state  (fsm_state)
    );

    // ------------------------------------------------------------------
    // AES-128 reference
    // ------------------------------------------------------------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // Behavioural core: samples its inputs every edge, answers LATENCY
    // cycles later, no reset and no stall.
    logic [127:0] core_pipe [LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= aes_enc(core_state, core_key);
        for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LATENCY-1];

    // Key the model believes is active for blocks accepted this cycle.
    logic [127:0] model_key = '0;
    always @(posedge clk) begin
        if (rst) model_key <= '0;
        else if (key_load) model_key <= key_in;
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q  [$];
    logic [EW-1:0] got_q  [$];
    logic [EW-1:0] pend_q [$];
    logic [31:0]   exp_done = '0;
    int n_acc, first_acc, last_acc;
    int n_pop = 0, first_pop = 0, last_pop = 0;
    bit rand_rdy = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every output transfer against the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("done_count", done_count, exp_done);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got 0x%0h, expected no output", {out_data, out_tag});
                end else begin
                    check("out_block", {out_data, out_tag}, exp_q.pop_front());
                end
                got_q.push_back({out_data, out_tag});
                if (n_pop == 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
                exp_done = exp_done + 32'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (entered and left 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        key_load = 1'b0;
        exp_q.delete();
        pend_q.delete();
        exp_done = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic key_pulse(input logic [127:0] k);
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk);
        #1 key_load = 1'b0;
    endtask

    // Offer pend_q blocks in order for at most max_cyc cycles. in_valid is
    // left high if blocks remain, so an offered block is never withdrawn.
    task automatic offer(input int max_cyc);
        for (int n = 0; n < max_cyc && pend_q.size() > 0; n++) begin
            in_valid = 1'b1;
            in_data  = pend_q[0][EW-1:TAG_W];
            in_tag   = pend_q[0][TAG_W-1:0];
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({aes_enc(in_data, model_key), in_tag});
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                void'(pend_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        if (pend_q.size() == 0) in_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            pend_q.push_back({$urandom, $urandom, $urandom, $urandom, 8'($urandom_range(0, 255))});
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            @(negedge clk);
            if (!busy && !out_valid) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: busy=%0b, expected idle within %0d cycles", busy, max_cyc);
        end
        check("exp_q_left", EW'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit seen;
        rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",   in_ready,   0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_busy",       busy,       0);
        check("rst_out_data",   out_data,   0);
        check("rst_out_tag",    out_tag,    0);
        check("rst_core_state", core_state, 0);
        check("rst_core_key",   core_key,   0);
        check("rst_fsm",        fsm_state,  0);
        @(posedge clk); #1;

        // No key: offered blocks are never accepted
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_tag   = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("nokey_in_ready", in_ready, 0);
        end
        check("nokey_out_valid", out_valid, 0);
        check("nokey_busy", busy, 0);
        @(posedge clk); #1 in_valid = 1'b0;

        key_pulse(C1_KEY);
        @(negedge clk);
        check("key_in_ready", in_ready, 1);
        check("key_fsm", fsm_state, 1);
        check("key_core_key", core_key, C1_KEY);
        @(posedge clk); #1;

        // FIPS-197 C.1 and first-output latency
        got_q.delete();
        n_acc = 0;
        pend_q.push_back({C1_PT, 8'h5A});
        offer(20);
        check("c1_accepted", n_acc, 1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("c1_out_seen", seen, 1);
        check("c1_latency", cyc - last_acc, 12);
        wait_idle(60);
        check("c1_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("c1_block", got_q[0], {C1_CT, 8'h5A});

        // Key switch: same-cycle accept uses the old key
        got_q.delete();
        n_acc = 0;
        key_load = 1'b1;
        key_in   = K2;
        pend_q.push_back({C1_PT, 8'h11});
        offer(1);
        key_load = 1'b0;
        check("ks_same_cycle_accept", n_acc, 1);
        pend_q.push_back({PT2, 8'h22});
        offer(20);
        wait_idle(60);
        check("ks_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("ks_old_key_block", got_q[0], {C1_CT, 8'h11});
            check("ks_new_key_block", got_q[1], {CT2, 8'h22});
        end

        // Backpressure: only FIFO_DEPTH blocks accepted while out_ready=0
        do_reset();
        key_pulse({$urandom, $urandom, $urandom, $urandom});
        out_ready = 1'b0;
        fill_random(40);
        n_acc = 0;
        offer(60);
        check("bp_accepted", n_acc, FIFO_DEPTH);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_busy", busy, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        got_q.delete();
        n_pop = 0;
        offer(400);
        check("bp_all_accepted", n_acc, 40);
        wait_idle(100);
        check("bp_popped", n_pop, 40);
        check("bp_done_count", done_count, 40);

        // Streaming: 100 blocks, one per cycle in and out
        fill_random(100);
        n_acc = 0;
        n_pop = 0;
        offer(300);
        check("st_accepted", n_acc, 100);
        check("st_accept_span", last_acc - first_acc, 99);
        wait_idle(100);
        check("st_popped", n_pop, 100);
        check("st_pop_span", last_pop - first_pop, 99);

        // Random backpressure with a key change mid-stream
        rand_rdy = 1;
        fill_random(30);
        n_acc = 0;
        offer(500);
        key_pulse({$urandom, $urandom, $urandom, $urandom});
        fill_random(30);
        offer(500);
        rand_rdy = 0;
        @(posedge clk); #1 out_ready = 1'b1;
        check("rnd_accepted", n_acc, 60);
        wait_idle(200);

        // Reset with 8 blocks in flight and 4 in the FIFO
        out_ready = 1'b0;
        fill_random(12);
        n_acc = 0;
        offer(12);
        check("mr_accepted", n_acc, 12);
        check("mr_accept_span", last_acc - first_acc, 11);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("mr_pre_busy", busy, 1);
        check("mr_pre_out_valid", out_valid, 1);
        @(posedge clk); #1;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("mr_out_valid", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_done_count", done_count, 0);
        check("mr_fsm", fsm_state, 0);
        check("mr_in_ready", in_ready, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("mr_no_stale", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
